// File: rtl/packet_source.sv
// Synthetic traffic source for one mesh node: LFSR-driven injection into a
// local queue, drained onto the network when backpressure allows.
module packet_source #(
   parameter int unsigned COORD_W    = 2,
   parameter int unsigned NODE_ID    = 0,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_enable,
   input  logic [7:0]         i_rate,
   input  logic [31:0]        i_timestamp,
   input  logic               i_net_full,
   output logic               o_pkt_valid,
   output logic [COORD_W-1:0] o_pkt_source_x,
   output logic [COORD_W-1:0] o_pkt_source_y,
   output logic [COORD_W-1:0] o_pkt_dest_x,
   output logic [COORD_W-1:0] o_pkt_dest_y,
   output logic [31:0]        o_pkt_data,
   output logic               o_fifo_error,
   output logic [31:0]        o_gen_count,
   output logic [31:0]        o_sent_count,
   output logic               o_busy
);

   localparam int unsigned NW = 2 * COORD_W;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [NW-1:0] NODE    = NW'(NODE_ID);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [NW-1:0] dest;
      logic [31:0]   data;
   } entry_t;

   state_t        state, next_state;
   logic [15:0]   lfsr, lfsr_next;
   entry_t        mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic          gen, pop, push, overflow, fifo_empty, fifo_full;
   logic [NW-1:0] raw_dest, dest;

   always_comb begin
      fifo_empty = (count == '0);
      fifo_full  = (count == DEPTH_C);
      gen        = (state == RUN) && i_enable && (lfsr[7:0] < i_rate);
      raw_dest   = lfsr[8 +: NW];
      // Never address ourselves: bump to the next node index, wrapping.
      dest       = (raw_dest == NODE) ? NODE + NW'(1) : raw_dest;
      pop        = !fifo_empty && !i_net_full;
      // A pop on a full queue frees the slot the push needs.
      push       = gen && (!fifo_full || pop);
      overflow   = gen && fifo_full && !pop;
      lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (i_enable) next_state = RUN;
         RUN:   if (!i_enable) next_state = fifo_empty ? IDLE : DRAIN;
         DRAIN: begin
            if (i_enable)        next_state = RUN;
            else if (fifo_empty) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{dest: dest, data: i_timestamp};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         lfsr           <= SEED;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         o_pkt_valid    <= 1'b0;
         o_pkt_source_x <= '0;
         o_pkt_source_y <= '0;
         o_pkt_dest_x   <= '0;
         o_pkt_dest_y   <= '0;
         o_pkt_data     <= '0;
         o_fifo_error   <= 1'b0;
         o_gen_count    <= '0;
         o_sent_count   <= '0;
      end else begin
         state <= next_state;
         if (state == RUN) lfsr <= lfsr_next;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW + 1)'(1);
         else if (pop && !push) count <= count - (AW + 1)'(1);
         o_pkt_valid <= pop;
         if (pop) begin
            o_pkt_source_x                <= NODE[NW-1:COORD_W];
            o_pkt_source_y                <= NODE[COORD_W-1:0];
            {o_pkt_dest_x, o_pkt_dest_y}  <= mem[rd_ptr].dest;
            o_pkt_data                    <= mem[rd_ptr].data;
            o_sent_count                  <= o_sent_count + 32'd1;
         end
         if (gen)      o_gen_count  <= o_gen_count + 32'd1;
         if (overflow) o_fifo_error <= 1'b1;
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_packet_source.sv
// Directed bench for packet_source with a cycle-level reference model of
// the queue, injection decision and control states.
module tb_packet_source;

   localparam int unsigned CW    = 2;
   localparam int unsigned NID   = 6;
   localparam int unsigned DEPTH = 8;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam logic [3:0]  NODE  = 4'(NID);

   logic          clk = 1'b0;
   logic          reset_n, i_enable, i_net_full;
   logic [7:0]    i_rate;
   logic [31:0]   i_timestamp;
   logic          o_pkt_valid, o_fifo_error, o_busy;
   logic [CW-1:0] o_pkt_source_x, o_pkt_source_y, o_pkt_dest_x, o_pkt_dest_y;
   logic [31:0]   o_pkt_data, o_gen_count, o_sent_count;

   always #5 clk = ~clk;

   packet_source #(.COORD_W(CW), .NODE_ID(NID), .FIFO_DEPTH(DEPTH), .SEED(SEED)) dut (
      .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_rate(i_rate),
      .i_timestamp(i_timestamp), .i_net_full(i_net_full), .o_pkt_valid(o_pkt_valid),
      .o_pkt_source_x(o_pkt_source_x), .o_pkt_source_y(o_pkt_source_y),
      .o_pkt_dest_x(o_pkt_dest_x), .o_pkt_dest_y(o_pkt_dest_y), .o_pkt_data(o_pkt_data),
      .o_fifo_error(o_fifo_error), .o_gen_count(o_gen_count),
      .o_sent_count(o_sent_count), .o_busy(o_busy)
   );

   int unsigned n_checks = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0]  dest;
      logic [31:0] data;
   } pkt_t;

   pkt_t        mq[$];
   pkt_t        e_pkt;
   int          m_state;  // 0 idle, 1 run, 2 drain
   logic [15:0] m_lfsr;
   logic [31:0] m_gen, m_sent;
   logic        m_err, e_valid;
   int unsigned cyc = 0;

   // One clock: advance the model with the current inputs, clock the DUT, compare.
   task automatic tick();
      int unsigned pre;
      int          old_state;
      bit          gen, pop;
      logic [3:0]  d;
      logic [31:0] ts;
      ts = 32'h1000_0000 + cyc * 7;
      i_timestamp = ts;
      if (!reset_n) begin
         m_state = 0; m_lfsr = SEED; mq.delete(); m_gen = '0; m_sent = '0;
         m_err = 1'b0; e_valid = 1'b0;
      end else begin
         pre = mq.size();
         old_state = m_state;
         gen = (m_state == 1) && i_enable && (m_lfsr[7:0] < i_rate);
         pop = (pre != 0) && !i_net_full;
         e_valid = pop;
         if (pop) begin
            e_pkt = mq.pop_front();
            m_sent++;
         end
         if (gen) begin
            d = m_lfsr[11:8];
            if (d == NODE) d = NODE + 4'd1;
            m_gen++;
            if (mq.size() < DEPTH) mq.push_back({d, ts});
            else m_err = 1'b1;
         end
         case (m_state)
            0: if (i_enable) m_state = 1;
            1: if (!i_enable) m_state = (pre != 0) ? 2 : 0;
            default: if (i_enable) m_state = 1; else if (pre == 0) m_state = 0;
         endcase
         if (old_state == 1) m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
      end
      @(posedge clk);
      #1;
      chk("valid", o_pkt_valid, e_valid);
      if (e_valid) begin
         chk("pkt", {o_pkt_source_x, o_pkt_source_y, o_pkt_dest_x, o_pkt_dest_y, o_pkt_data},
             {NODE, e_pkt.dest, e_pkt.data});
         chk("dest_not_own", {o_pkt_dest_x, o_pkt_dest_y} == NODE, 0);
      end
      chk("gen_count", o_gen_count, m_gen);
      chk("sent_count", o_sent_count, m_sent);
      chk("fifo_error", o_fifo_error, m_err);
      chk("busy", o_busy, m_state != 0);
      cyc++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int unsigned nv;
      reset_n = 1'b0; i_enable = 1'b0; i_rate = '0; i_net_full = 1'b0; i_timestamp = '0;
      tick();
      tick();
      chk("rst_fields", {o_pkt_source_x, o_pkt_source_y, o_pkt_dest_x, o_pkt_dest_y, o_pkt_data}, 0);
      chk("rst_lfsr", dut.lfsr, SEED);
      chk("rst_occ", dut.count, 0);
      reset_n = 1'b1;

      // Zero rate: running but silent
      i_enable = 1'b1; i_rate = 8'd0;
      repeat (1000) tick();
      chk("rate0_gen", o_gen_count, 0);
      chk("rate0_busy", o_busy, 1);
      i_enable = 1'b0;
      tick();
      chk("rate0_to_idle", o_busy, 0);

      // Full rate, open network
      i_enable = 1'b1; i_rate = 8'd255;
      repeat (1000) tick();
      chk("full_rate_close", (o_gen_count - o_sent_count) <= 1, 1);
      chk("full_rate_many", o_gen_count > 900, 1);
      i_enable = 1'b0;
      repeat (3) tick();
      chk("full_rate_idle", o_busy, 0);

      // Backpressure: queue fills then overflows
      do_reset();
      i_enable = 1'b1; i_rate = 8'd255; i_net_full = 1'b1;
      repeat (50) tick();
      chk("ovf_occ", dut.count, 8);
      chk("ovf_err", o_fifo_error, 1);
      chk("ovf_gen_gt8", o_gen_count > 8, 1);
      chk("ovf_sent", o_sent_count, 0);

      // Full queue with push and pop together
      do_reset();
      chk("err_cleared", o_fifo_error, 0);
      i_enable = 1'b1; i_rate = 8'd255; i_net_full = 1'b1;
      for (int i = 0; i < 40 && mq.size() < DEPTH; i++) tick();
      chk("fill_occ", dut.count, 8);
      i_net_full = 1'b0;
      repeat (30) begin
         tick();
         chk("steady_occ", dut.count, mq.size());
      end
      chk("steady_err", o_fifo_error, 0);

      // Drain three queued packets after disable
      do_reset();
      i_enable = 1'b1; i_rate = 8'd255; i_net_full = 1'b1;
      for (int i = 0; i < 20 && mq.size() < 3; i++) tick();
      chk("drain_pre_occ", dut.count, 3);
      i_enable = 1'b0; i_net_full = 1'b0;
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (o_pkt_valid) nv++;
         if (i < 3) chk("drain_consecutive", o_pkt_valid, 1);
      end
      chk("drain_count", nv, 3);
      chk("drain_idle", o_busy, 0);

      // Reset mid-operation with five queued
      do_reset();
      i_enable = 1'b1; i_rate = 8'd255; i_net_full = 1'b1;
      for (int i = 0; i < 20 && mq.size() < 5; i++) tick();
      chk("mid_pre_occ", dut.count, 5);
      reset_n = 1'b0; i_net_full = 1'b0;
      tick();
      chk("mid_rst_valid", o_pkt_valid, 0);
      chk("mid_rst_gen", o_gen_count, 0);
      chk("mid_rst_sent", o_sent_count, 0);
      chk("mid_rst_err", o_fifo_error, 0);
      chk("mid_rst_lfsr", dut.lfsr, SEED);
      chk("mid_rst_occ", dut.count, 0);
      reset_n = 1'b1;
      tick();
      chk("mid_post_valid", o_pkt_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
